node_input_sequencer: RTL and testbench
=======================================

// Module: node_input_sequencer
// PURPOSE
//  Parametrised sequencer that walks (node, input) index pairs for a neural-layer MAC datapath.
//  Successor to the single-level input timer: adds node-level nesting, a start/busy/done handshake,
//  stall-without-clear on coef_ready, a pipeline drain and single/continuous modes.
//  Sits between the layer controller and the coefficient/MAC pipeline.
// PARAMETERS
//  IN_W      7  width of input index and max_input
//  NODE_W    5  width of node index and max_node
//  PIPE_LAT  3  MAC pipeline depth; drain cycles before done (1..15)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  start       in   1       launch request; accepted only in IDLE
//  abort       in   1       synchronous cancel; returns to IDLE next cycle
//  continuous  in   1       latched at start: 1 = restart pass automatically after done
//  max_input   in   IN_W    last input index (inclusive), latched at start
//  max_node    in   NODE_W  last node index (inclusive), latched at start
//  coef_ready  in   1       coefficient valid; low stalls the walk (indices hold)
//  busy        out  1       high in RUN or DRAIN
//  issue       out  1       (node_num, input_num) valid and consumed this cycle
//  input_num   out  IN_W    current input index
//  node_num    out  NODE_W  current node index
//  acc_clear   out  1       issue && input_num == 0
//  acc_last    out  1       issue && input_num == max_input (latched)
//  done        out  1       one-cycle pulse when the pass completes
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; latched config 0.
//  States: IDLE -> RUN on start (abort low). RUN -> DRAIN after issue of (max_node, max_input).
//   DRAIN counts PIPE_LAT cycles -> DONE. DONE (1 cycle, done=1) -> RUN if continuous_q else IDLE.
//   abort in any state -> IDLE next cycle, no done pulse; abort has priority over start.
//  Latency: start sampled in cycle 0; first issue possible in cycle 1 (RUN entry).
//  issue = (state==RUN) && coef_ready. Each issue advances input_num; input_num wraps
//   max_input -> 0 and node_num increments on the same edge. Counters hold when issue=0 (stall).
//  Counters clear to 0 on entering RUN from IDLE or DONE.
//  max_input=0: every issue is both acc_clear and acc_last. max_node=0: single node pass.
//  Total issues per pass = (max_input+1)*(max_node+1); done asserts exactly PIPE_LAT+1 cycles after last issue.
//  start while busy/DONE ignored; config inputs ignored outside IDLE->RUN edge.
//  Continuous restart re-uses latched config; DONE->RUN re-clears counters, no bubble beyond DONE cycle.
//  Reset mid-operation: immediate return to reset values, regardless of state.
//  All arithmetic unsigned; counters never exceed latched max (compare ==, not >=).
// STRUCTURE
//  Package nn_seq_pkg: typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DRAIN, SEQ_DONE} seq_state_t;
//   localparam PIPE_LAT_W = 4.
//  Sub-module wrap_counter #(W): clear, enable, max, count, wrap flag; instantiated twice
//   (input level enabled by issue, node level enabled by issue && input wrap) plus FSM and drain counter.
// TESTING
//  1 max_input=3,max_node=1,coef_ready=1,start pulse -> 8 issues, acc_clear at input 0, acc_last at
//    input 3, done exactly PIPE_LAT+1 cycles after 8th issue, busy low after done.
//  2 Same config, coef_ready low for 5 cycles mid-node at input 2 -> indices hold at 2, no issue, resume
//    to 3; total issues still 8.
//  3 max_input=0,max_node=0 -> single issue with acc_clear=acc_last=1, then done.
//  4 continuous=1, max_input=2,max_node=0 -> done every 3+PIPE_LAT+1 cycles; start during RUN ignored.
//  5 abort asserted at issue 4 of 8 -> IDLE next cycle, no done, outputs 0; fresh start works.
//  6 rst asserted asynchronously mid-DRAIN -> all outputs 0 before next edge; max_input changed
//    during RUN has no effect on the pass in progress.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the node/input index sequencer.
package nn_seq_pkg;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DRAIN, SEQ_DONE} seq_state_t;
  localparam int unsigned PIPE_LAT_W = 4;
endpackage

// File: rtl/node_input_sequencer_if.sv
// Control/config inputs and index/strobe outputs of the node/input sequencer.
interface node_input_sequencer_if #(
  parameter int unsigned IN_W   = 7,
  parameter int unsigned NODE_W = 5
);
  logic              start;
  logic              abort;
  logic              continuous;
  logic [IN_W-1:0]   max_input;
  logic [NODE_W-1:0] max_node;
  logic              coef_ready;
  logic              busy;
  logic              issue;
  logic [IN_W-1:0]   input_num;
  logic [NODE_W-1:0] node_num;
  logic              acc_clear;
  logic              acc_last;
  logic              done;

  modport master (
    output start, abort, continuous, max_input, max_node, coef_ready,
    input  busy, issue, input_num, node_num, acc_clear, acc_last, done
  );

  modport slave (
    input  start, abort, continuous, max_input, max_node, coef_ready,
    output busy, issue, input_num, node_num, acc_clear, acc_last, done
  );
endinterface

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero after reaching an inclusive maximum; clear has priority.
module wrap_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] count,
  output logic         wrap
);
  logic [W-1:0] count_q, count_d;

  assign wrap  = (count_q == max_val);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/node_input_sequencer.sv
// Walks (node, input) index pairs for the MAC pipeline, then drains PIPE_LAT cycles before done.
module node_input_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned IN_W     = 7,
  parameter int unsigned NODE_W   = 5,
  parameter int unsigned PIPE_LAT = 3
) (
  input logic                   clk,
  input logic                   rst,
  node_input_sequencer_if.slave bus
);
  seq_state_t            state_q, state_d;
  logic [PIPE_LAT_W-1:0] drain_q, drain_d;
  logic [IN_W-1:0]       max_input_q;
  logic [NODE_W-1:0]     max_node_q;
  logic                  continuous_q;

  logic              cfg_load;
  logic              cnt_clear;
  logic              issue;
  logic              input_wrap;
  logic              node_wrap;
  logic              pass_last;
  logic [IN_W-1:0]   input_num;
  logic [NODE_W-1:0] node_num;

  assign issue     = (state_q == SEQ_RUN) && bus.coef_ready;
  assign pass_last = issue && input_wrap && node_wrap;

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    cfg_load  = 1'b0;
    cnt_clear = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (bus.start) begin
          state_d   = SEQ_RUN;
          cfg_load  = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      SEQ_RUN: begin
        if (pass_last) begin
          state_d = SEQ_DRAIN;
          drain_d = '0;
        end
      end
      SEQ_DRAIN: begin
        if (drain_q == PIPE_LAT_W'(PIPE_LAT - 1)) begin
          state_d = SEQ_DONE;
        end else begin
          drain_d = drain_q + PIPE_LAT_W'(1);
        end
      end
      SEQ_DONE: begin
        if (continuous_q) begin
          state_d   = SEQ_RUN;
          cnt_clear = 1'b1;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    // Abort outranks everything, including a start seen in the same cycle.
    if (bus.abort) begin
      state_d   = SEQ_IDLE;
      cfg_load  = 1'b0;
      cnt_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_input_q  <= '0;
      max_node_q   <= '0;
      continuous_q <= 1'b0;
    end else if (cfg_load) begin
      max_input_q  <= bus.max_input;
      max_node_q   <= bus.max_node;
      continuous_q <= bus.continuous;
    end
  end

  wrap_counter #(
    .W (IN_W)
  ) u_input_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (issue),
    .max_val (max_input_q),
    .count   (input_num),
    .wrap    (input_wrap)
  );

  // Node level steps on the same edge the input level wraps back to zero.
  wrap_counter #(
    .W (NODE_W)
  ) u_node_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (issue && input_wrap),
    .max_val (max_node_q),
    .count   (node_num),
    .wrap    (node_wrap)
  );

  assign bus.busy      = (state_q == SEQ_RUN) || (state_q == SEQ_DRAIN);
  assign bus.issue     = issue;
  assign bus.input_num = input_num;
  assign bus.node_num  = node_num;
  assign bus.acc_clear = issue && (input_num == '0);
  assign bus.acc_last  = issue && (input_num == max_input_q);
  assign bus.done      = (state_q == SEQ_DONE);
endmodule

// File: tb/tb_node_input_sequencer.sv
// Self-checking bench: issue streams compared against a nested-loop reference of each pass.
module tb_node_input_sequencer;
  localparam int unsigned IN_W     = 7;
  localparam int unsigned NODE_W   = 5;
  localparam int unsigned PIPE_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  node_input_sequencer_if #(.IN_W(IN_W), .NODE_W(NODE_W)) bus ();

  node_input_sequencer #(
    .IN_W     (IN_W),
    .NODE_W   (NODE_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Issue record: {node, input, acc_clear, acc_last}
  logic [NODE_W+IN_W+1:0] obs_code[$];
  logic [NODE_W+IN_W+1:0] exp_code[$];
  int obs_cyc[$];
  int done_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.issue) begin
        obs_code.push_back({bus.node_num, bus.input_num, bus.acc_clear, bus.acc_last});
        obs_cyc.push_back(cyc);
      end
      if (bus.done) done_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs;
    obs_code.delete();
    obs_cyc.delete();
    done_cyc.delete();
    exp_code.delete();
  endtask

  // Reference: one pass is every input of node 0, then every input of node 1, ...
  task automatic model_pass(input int mi, input int mn);
    for (int n = 0; n <= mn; n++) begin
      for (int i = 0; i <= mi; i++) begin
        exp_code.push_back({NODE_W'(n), IN_W'(i), (i == 0), (i == mi)});
      end
    end
  endtask

  task automatic drive_pass(input int mi, input int mn, input bit stall,
                            output int scyc, output bit tmo);
    bus.max_input  = IN_W'(mi);
    bus.max_node   = NODE_W'(mn);
    bus.continuous = 1'b0;
    bus.coef_ready = 1'b1;
    bus.start      = 1'b1;
    scyc           = cyc;
    step();
    bus.start     = 1'b0;
    bus.max_input = IN_W'($urandom_range(0, 127));
    bus.max_node  = NODE_W'($urandom_range(0, 31));
    tmo           = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (done_cyc.size() > 0) begin
        tmo = 1'b0;
        break;
      end
      bus.coef_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
    end
    bus.coef_ready = 1'b1;
  endtask

  task automatic test_reset;
    bus.start = 0; bus.abort = 0; bus.continuous = 0;
    bus.max_input = '0; bus.max_node = '0; bus.coef_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.issue, bus.input_num, bus.node_num, bus.acc_clear, bus.acc_last,
         bus.done} !== '0) begin
      failures++;
      $display("FAIL reset_hold: busy=%b issue=%b in=%0d node=%0d done=%b, required all 0",
               bus.busy, bus.issue, bus.input_num, bus.node_num, bus.done);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.issue, bus.input_num, bus.node_num, bus.acc_clear, bus.acc_last,
         bus.done} !== '0) begin
      failures++;
      $display("FAIL reset_release: busy=%b issue=%b in=%0d node=%0d done=%b, required all 0",
               bus.busy, bus.issue, bus.input_num, bus.node_num, bus.done);
    end
    step();
  endtask

  task automatic test_single_pass;
    int s;
    bit t;
    clear_obs();
    model_pass(3, 1);
    drive_pass(3, 1, 1'b0, s, t);
    checks++;
    if (t) begin failures++; $display("FAIL single_timeout: no done, required done"); end
    checks++;
    if (obs_code.size() != 8) begin
      failures++;
      $display("FAIL single_count: got %0d issues, required 8", obs_code.size());
    end
    for (int k = 0; k < exp_code.size() && k < obs_code.size(); k++) begin
      checks++;
      if (obs_code[k] !== exp_code[k]) begin
        failures++;
        $display("FAIL single_seq[%0d]: got %h, required %h", k, obs_code[k], exp_code[k]);
      end
    end
    checks++;
    if (obs_cyc.size() != 8 || obs_cyc[0] != s + 1 || obs_cyc[7] != s + 8) begin
      failures++;
      $display("FAIL single_latency: first/last issue not at cycles %0d/%0d", s + 1, s + 8);
    end
    checks++;
    if (obs_cyc.size() == 0 || done_cyc.size() != 1 ||
        done_cyc[0] != obs_cyc[obs_cyc.size()-1] + PIPE_LAT + 1) begin
      failures++;
      $display("FAIL single_done: %0d done pulses, required 1 at last issue + %0d",
               done_cyc.size(), PIPE_LAT + 1);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    step();
  endtask

  task automatic test_stall;
    bit stalled;
    bit fin;
    stalled = 1'b0;
    fin     = 1'b0;
    clear_obs();
    model_pass(3, 1);
    bus.max_input = IN_W'(3); bus.max_node = NODE_W'(1); bus.continuous = 1'b0;
    bus.coef_ready = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 100 && !fin; k++) begin
      if (!stalled && bus.node_num == 0 && bus.input_num == 2) begin
        bus.coef_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          checks++;
          if (bus.issue !== 1'b0 || bus.input_num !== IN_W'(2) || bus.node_num !== '0) begin
            failures++;
            $display("FAIL stall_hold[%0d]: issue=%b in=%0d node=%0d, required 0 2 0",
                     j, bus.issue, bus.input_num, bus.node_num);
          end
          step();
        end
        bus.coef_ready = 1'b1;
        stalled = 1'b1;
      end
      if (done_cyc.size() > 0) fin = 1'b1;
      else step();
    end
    checks++;
    if (!fin || !stalled) begin
      failures++;
      $display("FAIL stall_run: done=%b stalled=%b, required 1 1", fin, stalled);
    end
    checks++;
    if (obs_code.size() != 8) begin
      failures++;
      $display("FAIL stall_count: got %0d issues, required 8", obs_code.size());
    end
    for (int k = 0; k < exp_code.size() && k < obs_code.size(); k++) begin
      checks++;
      if (obs_code[k] !== exp_code[k]) begin
        failures++;
        $display("FAIL stall_seq[%0d]: got %h, required %h", k, obs_code[k], exp_code[k]);
      end
    end
    checks++;
    if (obs_cyc.size() < 3 || obs_cyc[2] - obs_cyc[1] != 6) begin
      failures++;
      $display("FAIL stall_gap: gap between issue 1 and 2 not 6 cycles");
    end
    step();
  endtask

  task automatic test_min;
    int s;
    bit t;
    clear_obs();
    model_pass(0, 0);
    drive_pass(0, 0, 1'b0, s, t);
    checks++;
    if (t || obs_code.size() != 1) begin
      failures++;
      $display("FAIL min_count: timeout=%b issues=%0d, required 0 1", t, obs_code.size());
    end
    checks++;
    if (obs_code.size() < 1 || obs_code[0] !== exp_code[0]) begin
      failures++;
      $display("FAIL min_code: got %h, required %h",
               (obs_code.size() > 0) ? obs_code[0] : '0, exp_code[0]);
    end
    checks++;
    if (obs_cyc.size() < 1 || done_cyc.size() != 1 || done_cyc[0] != obs_cyc[0] + PIPE_LAT + 1)
    begin
      failures++;
      $display("FAIL min_done: %0d done pulses, required 1 at issue + %0d",
               done_cyc.size(), PIPE_LAT + 1);
    end
    step();
  endtask

  task automatic test_continuous;
    int s;
    bit fin;
    fin = 1'b0;
    clear_obs();
    repeat (3) model_pass(2, 0);
    bus.max_input = IN_W'(2); bus.max_node = '0; bus.continuous = 1'b1;
    bus.coef_ready = 1'b1; bus.start = 1'b1;
    s = cyc;
    step();
    bus.start = 1'b0; bus.continuous = 1'b0;
    for (int k = 0; k < 200; k++) begin
      bus.start = (k == 1);
      if (k == 1) begin bus.max_input = IN_W'(5); bus.max_node = NODE_W'(2); end
      if (done_cyc.size() >= 3) begin fin = 1'b1; break; end
      step();
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checks++;
    if (!fin) begin failures++; $display("FAIL cont_timeout: <3 done pulses, required 3"); end
    for (int k = 0; k < 9 && k < obs_code.size(); k++) begin
      checks++;
      if (obs_code[k] !== exp_code[k]) begin
        failures++;
        $display("FAIL cont_seq[%0d]: got %h, required %h", k, obs_code[k], exp_code[k]);
      end
    end
    checks++;
    if (done_cyc.size() < 3 || done_cyc[1] - done_cyc[0] != 3 + PIPE_LAT + 1 ||
        done_cyc[2] - done_cyc[1] != 3 + PIPE_LAT + 1) begin
      failures++;
      $display("FAIL cont_period: done spacing wrong, required %0d cycles", 3 + PIPE_LAT + 1);
    end
    checks++;
    if (obs_cyc.size() < 3 || obs_cyc[0] != s + 1 || done_cyc.size() < 1 ||
        done_cyc[0] != obs_cyc[2] + PIPE_LAT + 1) begin
      failures++;
      $display("FAIL cont_first: first pass timing wrong from start cycle %0d", s);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_abort: busy=%b, required 0", bus.busy);
    end
    step();
  endtask

  task automatic test_abort;
    int s;
    bit t;
    clear_obs();
    model_pass(3, 1);
    bus.max_input = IN_W'(3); bus.max_node = NODE_W'(1); bus.continuous = 1'b0;
    bus.coef_ready = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.issue, bus.input_num, bus.node_num, bus.acc_clear, bus.acc_last,
         bus.done} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b issue=%b in=%0d node=%0d, required all 0",
               bus.busy, bus.issue, bus.input_num, bus.node_num);
    end
    repeat (12) step();
    checks++;
    if (obs_code.size() != 4 || done_cyc.size() != 0) begin
      failures++;
      $display("FAIL abort_stop: issues=%0d done=%0d, required 4 0",
               obs_code.size(), done_cyc.size());
    end
    for (int k = 0; k < 4 && k < obs_code.size(); k++) begin
      checks++;
      if (obs_code[k] !== exp_code[k]) begin
        failures++;
        $display("FAIL abort_seq[%0d]: got %h, required %h", k, obs_code[k], exp_code[k]);
      end
    end
    clear_obs();
    model_pass(1, 1);
    drive_pass(1, 1, 1'b0, s, t);
    checks++;
    if (t || obs_code.size() != 4 || done_cyc.size() != 1 || obs_code[3] !== exp_code[3]) begin
      failures++;
      $display("FAIL abort_restart: timeout=%b issues=%0d done=%0d, required 0 4 1",
               t, obs_code.size(), done_cyc.size());
    end
    step();
  endtask

  task automatic test_reset_mid_drain;
    bit reached;
    reached = 1'b0;
    clear_obs();
    model_pass(3, 1);
    bus.max_input = IN_W'(3); bus.max_node = NODE_W'(1); bus.continuous = 1'b0;
    bus.coef_ready = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.max_input = '0;
    for (int k = 0; k < 50; k++) begin
      if (obs_code.size() >= 8) begin reached = 1'b1; break; end
      step();
    end
    checks++;
    if (!reached || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL drain_entry: reached=%b busy=%b, required 1 1", reached, bus.busy);
    end
    for (int k = 0; k < exp_code.size() && k < obs_code.size(); k++) begin
      checks++;
      if (obs_code[k] !== exp_code[k]) begin
        failures++;
        $display("FAIL latch_seq[%0d]: got %h, required %h", k, obs_code[k], exp_code[k]);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.issue, bus.input_num, bus.node_num, bus.acc_clear, bus.acc_last,
         bus.done} !== '0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b in=%0d node=%0d, required all 0",
               bus.busy, bus.done, bus.input_num, bus.node_num);
    end
    step();
    rst = 1'b0;
    repeat (8) step();
    checks++;
    if (done_cyc.size() != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done: done=%0d busy=%b, required 0 0", done_cyc.size(), bus.busy);
    end
  endtask

  task automatic test_random;
    int s, mi, mn;
    bit t;
    for (int r = 0; r < 6; r++) begin
      mi = $urandom_range(0, 4);
      mn = $urandom_range(0, 3);
      clear_obs();
      model_pass(mi, mn);
      drive_pass(mi, mn, 1'b1, s, t);
      checks++;
      if (t || obs_code.size() != exp_code.size()) begin
        failures++;
        $display("FAIL rand%0d_count: timeout=%b issues=%0d, required 0 %0d",
                 r, t, obs_code.size(), exp_code.size());
      end
      for (int k = 0; k < exp_code.size() && k < obs_code.size(); k++) begin
        checks++;
        if (obs_code[k] !== exp_code[k]) begin
          failures++;
          $display("FAIL rand%0d_seq[%0d]: got %h, required %h", r, k, obs_code[k], exp_code[k]);
        end
      end
      checks++;
      if (obs_cyc.size() == 0 || done_cyc.size() != 1 ||
          done_cyc[0] != obs_cyc[obs_cyc.size()-1] + PIPE_LAT + 1) begin
        failures++;
        $display("FAIL rand%0d_done: %0d done pulses, required 1 at last issue + %0d",
                 r, done_cyc.size(), PIPE_LAT + 1);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_stall();
    test_min();
    test_continuous();
    test_abort();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
